// File: rtl/max_pool_unit.sv
// Streaming max-pooling stage: emits the maximum of every WINDOW consecutive
// accepted IEEE-754 single-precision activations over valid/ready handshakes.
module max_pool_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int WINDOW     = 4,
  parameter int CNT_WIDTH  = 8,
  parameter int IDX_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [IDX_WIDTH-1:0]  out_idx
);

  typedef enum logic [1:0] {
    ST_FIRST,
    ST_ACCUM,
    ST_OUT
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(WINDOW - 1);
  localparam bit                   SINGLE   = (WINDOW == 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [CNT_WIDTH-1:0]    cnt;
  logic [DATA_WIDTH-1:0]   max_reg;
  logic [DATA_WIDTH-1:0]   next_max;
  logic                    cmp_gt;
  logic                    accept;
  logic                    out_hs;
  logic                    load_first;
  logic                    load_accum;
  logic                    emit;

  // Floating-point greater-than on sign/magnitude; +0 and -0 compare equal,
  // and ties keep the running maximum (the earlier value).
  always_comb begin
    logic                  sa;
    logic                  sb;
    logic [DATA_WIDTH-2:0] ma;
    logic [DATA_WIDTH-2:0] mb;
    logic                  both_zero;
    sa        = in_data[DATA_WIDTH-1];
    sb        = max_reg[DATA_WIDTH-1];
    ma        = in_data[DATA_WIDTH-2:0];
    mb        = max_reg[DATA_WIDTH-2:0];
    both_zero = (ma == '0) && (mb == '0);
    cmp_gt    = 1'b0;
    case ({sa, sb})
      2'b00:   cmp_gt = (ma > mb);
      2'b01:   cmp_gt = !both_zero;
      2'b10:   cmp_gt = 1'b0;
      default: cmp_gt = (ma < mb);
    endcase
    next_max = cmp_gt ? in_data : max_reg;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FIRST;
    else        state <= state_nxt;
  end

  // Next-state decode; clear overrides every handshake.
  always_comb begin
    state_nxt = state;
    if (clear)                            state_nxt = ST_FIRST;
    else if (emit)                        state_nxt = ST_OUT;
    else if (load_first)                  state_nxt = ST_ACCUM;
    else if (state == ST_OUT && out_hs)   state_nxt = ST_FIRST;
  end

  // Handshake and datapath-control decode.
  // In ST_OUT an accept implies the output handshake, so it starts a new window.
  always_comb begin
    in_ready   = rst_n & ((state != ST_OUT) | out_ready);
    accept     = in_valid & in_ready;
    out_hs     = out_valid & out_ready;
    load_first = !clear & accept & ((state == ST_FIRST) | ((state == ST_OUT) & out_hs));
    load_accum = !clear & accept & (state == ST_ACCUM);
    emit       = (load_first & SINGLE) | (load_accum & (cnt == CNT_LAST));
  end

  // Running maximum, element counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      max_reg   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
    end else if (clear) begin
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (out_hs) begin
        out_valid <= 1'b0;
        out_idx   <= out_idx + IDX_WIDTH'(1);
      end
      if (load_first) begin
        max_reg <= in_data;
        cnt     <= CNT_WIDTH'(1);
      end
      if (load_accum) begin
        max_reg <= next_max;
        cnt     <= emit ? '0 : cnt + CNT_WIDTH'(1);
      end
      // Placed after the handshake update so a same-cycle completion wins.
      if (emit) begin
        out_valid <= 1'b1;
        out_data  <= load_first ? in_data : next_max;
      end
    end
  end

endmodule

// File: tb/tb_max_pool_unit.sv
// Directed self-checking bench for max_pool_unit (WINDOW=4).
module tb_max_pool_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_idx;

  int checks = 0;
  int errors = 0;
  int exp_idx = 0;

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] d3;
    logic [31:0] exp_max;
  } vec_t;

  vec_t tbl[10];

  max_pool_unit #(
    .DATA_WIDTH(32),
    .WINDOW(4),
    .CNT_WIDTH(8),
    .IDX_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clear(clear),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic [31:0] d,
                              input logic [31:0] e);
    vec_t v;
    v.d0 = a; v.d1 = b; v.d2 = c; v.d3 = d; v.exp_max = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Present one element and step past the accepting edge.
  task automatic feed(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  // One back-to-back window with out_ready=1; the result is handshaken on the next edge.
  task automatic run_window(input vec_t v, input string name);
    logic [31:0] d [4];
    d[0] = v.d0; d[1] = v.d1; d[2] = v.d2; d[3] = v.d3;
    for (int i = 0; i < 4; i++) begin
      feed(d[i]);
      if (i < 3) check({name, "_valid_early"}, {31'b0, out_valid}, 32'd0);
    end
    check({name, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({name, "_data"}, out_data, v.exp_max);
    check({name, "_idx"}, {24'b0, out_idx}, exp_idx[31:0] & 32'hFF);
    exp_idx++;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = mk(32'h3F000000, 32'h3F800000, 32'hC0000000, 32'h3E800000, 32'h3F800000);
    tbl[1] = mk(32'hC0400000, 32'hBF800000, 32'hC0000000, 32'hC0800000, 32'hBF800000);
    tbl[2] = mk(32'h00000000, 32'h80000000, 32'h80000000, 32'h00000000, 32'h00000000);
    tbl[3] = mk(32'h80000000, 32'h00000000, 32'h00000000, 32'h80000000, 32'h80000000);
    tbl[4] = mk(32'h3F800000, 32'h3F800001, 32'h3F800000, 32'h3F7FFFFF, 32'h3F800001);
    tbl[5] = mk(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 32'h00000001, 32'h7F800000);
    tbl[6] = mk(32'hFF800000, 32'hBF800000, 32'hC2C80000, 32'hFF800000, 32'hBF800000);
    tbl[7] = mk(32'h00000001, 32'h80000001, 32'h00000000, 32'h80000000, 32'h00000001);
    tbl[8] = mk(32'h3E800000, 32'h3F000000, 32'h3F400000, 32'h3F800000, 32'h3F800000);
    tbl[9] = mk(32'hC0000000, 32'hC0400000, 32'hC0800000, 32'hBF000000, 32'hBF000000);

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #1;
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_ready", {31'b0, in_ready}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_idx", {24'b0, out_idx}, 32'd0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table: back-to-back windows, no bubbles.
    for (int i = 0; i < 10; i++) run_window(tbl[i], $sformatf("tbl%0d", i));
    idle_cycle();
    check("tbl_drain_valid", {31'b0, out_valid}, 32'd0);
    check("tbl_drain_idx", {24'b0, out_idx}, exp_idx[31:0]);

    // Backpressure: result held, input stalled, then handshake + new first element.
    out_ready = 1'b0;
    feed(32'h3F800000); feed(32'h40000000); feed(32'h3F000000); feed(32'h3E800000);
    check("bp_valid", {31'b0, out_valid}, 32'd1);
    check("bp_data", out_data, 32'h40000000);
    in_data = 32'h41000000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      check("bp_hold_ready", {31'b0, in_ready}, 32'd0);
      check("bp_hold_data", out_data, 32'h40000000);
      check("bp_hold_idx", {24'b0, out_idx}, exp_idx[31:0]);
    end
    out_ready = 1'b1;
    in_data   = 32'h40400000;
    #1;
    check("bp_release_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    exp_idx++;
    check("bp_hs_valid", {31'b0, out_valid}, 32'd0);
    check("bp_hs_idx", {24'b0, out_idx}, exp_idx[31:0]);
    feed(32'h3F800000); feed(32'h3F000000); feed(32'h3E800000);
    check("bp_next_valid", {31'b0, out_valid}, 32'd1);
    check("bp_next_data", out_data, 32'h40400000);
    exp_idx++;
    idle_cycle();

    // clear mid-window: partial window and the clear-cycle input are dropped.
    feed(32'h42000000); feed(32'h41000000);
    clear = 1'b1; in_data = 32'h7F000000;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    check("clr_mid_valid", {31'b0, out_valid}, 32'd0);
    run_window(mk(32'h40000000, 32'h3F800000, 32'h3F000000, 32'h3E800000, 32'h40000000), "clr_mid");
    idle_cycle();

    // clear beats a same-cycle output handshake: result discarded, index kept.
    out_ready = 1'b0;
    feed(32'h3F800000); feed(32'h3F000000); feed(32'h3E800000); feed(32'h3E000000);
    check("clr_pend_valid", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b1; clear = 1'b1; in_valid = 1'b1; in_data = 32'h7F000000;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    check("clr_pend_drop", {31'b0, out_valid}, 32'd0);
    check("clr_pend_idx", {24'b0, out_idx}, exp_idx[31:0]);
    run_window(mk(32'h3E800000, 32'h3F800000, 32'h3F000000, 32'h3E000000, 32'h3F800000), "clr_pend");
    idle_cycle();

    // Asynchronous reset between edges with two elements accumulated.
    feed(32'h41000000); feed(32'h40000000);
    in_valid = 1'b1; in_data = 32'h3F800000;
    #3 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'b0, out_valid}, 32'd0);
    check("arst_ready", {31'b0, in_ready}, 32'd0);
    check("arst_idx", {24'b0, out_idx}, 32'd0);
    check("arst_data", out_data, 32'd0);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    exp_idx = 0;
    run_window(tbl[0], "arst_win");

    // Index wrap over 256 windows of signed zeros.
    for (int i = 0; i < 256; i++) run_window(tbl[2], "wrap");
    idle_cycle();
    check("wrap_final_idx", {24'b0, out_idx}, exp_idx[31:0] & 32'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
